// File: rtl/alu_operand_stage_pkg.sv
// Shared encodings for the ALU operand stage.
// Holds the B-source select codes and the literal-prefix FSM states.
package alu_operand_stage_pkg;

  typedef enum logic [1:0] {
    B_PC  = 2'd0,
    B_N   = 2'd1,
    B_R   = 2'd2,
    B_MEM = 2'd3
  } b_sel_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PFX  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_operand_stage_imm_gen.sv
// Immediate generator: sign-extends imm, or with ALU_OPND_LITPFX_EN
// concatenates it onto a prefix-accumulated wide literal.
module alu_opnd_imm_gen
  import alu_operand_stage_pkg::*;
#(
  parameter int W     = 16,
  parameter int IMM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             accept,
  input  logic             prefix,
  input  logic [IMM_W-1:0] imm,
  output logic             is_pfx,
  output logic [W-1:0]     imm_val
);

  logic [W-1:0] sext;

  assign sext = {{(W-IMM_W){imm[IMM_W-1]}}, imm};

`ifdef ALU_OPND_LITPFX_EN
  state_e       state, state_nx;
  logic [W-1:0] acc, acc_nx;
  logic [W-1:0] zext;
  logic [W-1:0] cat;

  assign zext    = {{(W-IMM_W){1'b0}}, imm};
  assign cat     = (acc << IMM_W) | zext;
  assign is_pfx  = prefix;
  assign imm_val = (state == ST_PFX) ? cat : sext;

  // flush outranks any accept in the same cycle
  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    if (flush) begin
      state_nx = ST_IDLE;
      acc_nx   = '0;
    end else if (accept && prefix) begin
      state_nx = ST_PFX;
      acc_nx   = (state == ST_PFX) ? cat : zext;
    end else if (accept) begin
      state_nx = ST_IDLE;
      acc_nx   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      acc   <= '0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
    end
  end
`else
  logic unused;

  assign unused  = ^{clk, rst, flush, accept, prefix};
  assign is_pfx  = 1'b0;
  assign imm_val = sext;
`endif

endmodule

// File: rtl/alu_operand_stage.sv
// One-deep ALU operand register with valid/ready handshake.
// Optional wide-literal prefixes via ALU_OPND_LITPFX_EN.
module alu_operand_stage
  import alu_operand_stage_pkg::*;
#(
  parameter int W     = 16,
  parameter int IMM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       b_op,
  input  logic             swap,
  input  logic             select_imm,
  input  logic             prefix,
  input  logic [W-1:0]     t,
  input  logic [W-1:0]     pc,
  input  logic [W-1:0]     n,
  input  logic [W-1:0]     r,
  input  logic [W-1:0]     mem,
  input  logic [IMM_W-1:0] imm,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     a,
  output logic [W-1:0]     b
);

  logic         accept;
  logic         is_pfx;
  logic         op_load;
  logic [W-1:0] imm_val;
  logic [W-1:0] src;
  logic [W-1:0] x;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign op_load  = accept && !is_pfx && !flush;

  alu_opnd_imm_gen #(
    .W     (W),
    .IMM_W (IMM_W)
  ) u_imm_gen (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .accept  (accept),
    .prefix  (prefix),
    .imm     (imm),
    .is_pfx  (is_pfx),
    .imm_val (imm_val)
  );

  always_comb begin
    src = pc;
    case (b_op)
      B_PC:    src = pc;
      B_N:     src = n;
      B_R:     src = r;
      B_MEM:   src = mem;
      default: src = pc;
    endcase
  end

  assign x = select_imm ? imm_val : src;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      a         <= '0;
      b         <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (op_load) begin
      out_valid <= 1'b1;
      a         <= swap ? x : t;
      b         <= swap ? t : x;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage (W=16, IMM_W=8).
// Directed scenarios plus randomized traffic against a behavioural model.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  b_op;
  logic        swap;
  logic        select_imm;
  logic        prefix;
  logic [15:0] t, pc, n, r, mem;
  logic [7:0]  imm;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] a, b;

  int n_pass  = 0;
  int n_total = 0;

  logic        m_valid;
  logic [15:0] m_a, m_b;
  logic [7:0]  m_pfx[$];

  alu_operand_stage #(.W(16), .IMM_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .b_op       (b_op),
    .swap       (swap),
    .select_imm (select_imm),
    .prefix     (prefix),
    .t          (t),
    .pc         (pc),
    .n          (n),
    .r          (r),
    .mem        (mem),
    .imm        (imm),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .a          (a),
    .b          (b)
  );

  always #5 clk = ~clk;

  function automatic logic pfx_on();
`ifdef ALU_OPND_LITPFX_EN
    return prefix;
`else
    return 1'b0;
`endif
  endfunction

  // Immediate as the spec describes it: pending prefix bytes followed by
  // imm, truncated to 16 bits; otherwise imm sign-extended.
  function automatic logic [15:0] m_imm();
    int v;
    if (m_pfx.size() == 0) begin
      v = int'(imm);
      if (v >= 128) v = v - 256;
      return 16'(v);
    end
    v = 0;
    foreach (m_pfx[i]) v = ((v * 256) + int'(m_pfx[i])) % 65536;
    v = ((v * 256) + int'(imm)) % 65536;
    return 16'(v);
  endfunction

  function automatic logic [15:0] m_src();
    if (select_imm) return m_imm();
    if (b_op == 2'd0) return pc;
    if (b_op == 2'd1) return n;
    if (b_op == 2'd2) return r;
    return mem;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_a = 16'h0;
    m_b = 16'h0;
    m_pfx.delete();
  endtask

  // One clock: predict from current inputs, advance, settle 1 time unit.
  task automatic step();
    logic        acc, p;
    logic [15:0] xv;
    acc = in_valid && (!m_valid || out_ready) && !flush;
    p   = pfx_on();
    xv  = m_src();
    @(posedge clk);
    #1;
    if (flush) begin
      m_valid = 1'b0;
      m_pfx.delete();
    end else begin
      if (m_valid && out_ready) m_valid = 1'b0;
      if (acc && p) begin
        m_pfx.push_back(imm);
      end else if (acc) begin
        m_a = swap ? xv : t;
        m_b = swap ? t : xv;
        m_valid = 1'b1;
        m_pfx.delete();
      end
    end
  endtask

  task automatic idle_inputs();
    in_valid = 0; b_op = 0; swap = 0; select_imm = 0; prefix = 0;
    t = 0; pc = 0; n = 0; r = 0; mem = 0; imm = 0;
    flush = 0; out_ready = 1;
  endtask

  task automatic drain();
    idle_inputs();
    step();
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    model_reset();
    #12;
    n_total++;
    if (out_valid !== 1'b0 || a !== 16'h0 || b !== 16'h0) begin
      $display("FAIL reset_state: got v=%b a=%h b=%h need v=0 a=0 b=0",
               out_valid, a, b);
    end else n_pass++;
    @(posedge clk);
    #1;
    rst = 0;
    #1;
    n_total++;
    if (in_ready !== 1'b1) begin
      $display("FAIL reset_ready: got %b need 1", in_ready);
    end else n_pass++;
  endtask

  task automatic test_basic_ops();
    idle_inputs();
    in_valid = 1; select_imm = 1; imm = 8'h80; t = 16'h0005;
    step();
    n_total++;
    if (out_valid !== 1'b1 || a !== 16'h0005 || b !== 16'hFF80) begin
      $display("FAIL sext_imm: got v=%b a=%h b=%h need v=1 a=0005 b=FF80",
               out_valid, a, b);
    end else n_pass++;
    select_imm = 0; b_op = 2; swap = 1; r = 16'h1234; t = 16'h00AA;
    step();
    n_total++;
    if (out_valid !== 1'b1 || a !== 16'h1234 || b !== 16'h00AA) begin
      $display("FAIL swap_r: got v=%b a=%h b=%h need v=1 a=1234 b=00AA",
               out_valid, a, b);
    end else n_pass++;
    in_valid = 0;
    step();
    n_total++;
    if (out_valid !== 1'b0) begin
      $display("FAIL consume_drop: got v=%b need 0", out_valid);
    end else n_pass++;
  endtask

  task automatic test_stall();
    idle_inputs();
    in_valid = 1; b_op = 1; n = 16'h1111; t = 16'h2222; out_ready = 0;
    step();
    n = 16'h3333; t = 16'h4444; b_op = 3; mem = 16'h5555;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++;
      if (in_ready !== 1'b0) begin
        $display("FAIL stall_ready[%0d]: got %b need 0", i, in_ready);
      end else n_pass++;
      step();
      n_total++;
      if (out_valid !== 1'b1 || a !== 16'h2222 || b !== 16'h1111) begin
        $display("FAIL stall_hold[%0d]: got v=%b a=%h b=%h need 1 2222 1111",
                 i, out_valid, a, b);
      end else n_pass++;
    end
    out_ready = 1;
    #1;
    n_total++;
    if (in_ready !== 1'b1) begin
      $display("FAIL release_ready: got %b need 1", in_ready);
    end else n_pass++;
    step();
    n_total++;
    if (out_valid !== 1'b1 || a !== 16'h4444 || b !== 16'h5555) begin
      $display("FAIL back_to_back: got v=%b a=%h b=%h need 1 4444 5555",
               out_valid, a, b);
    end else n_pass++;
    drain();
  endtask

  task automatic test_flush();
    idle_inputs();
    in_valid = 1; b_op = 0; pc = 16'hBEEF; flush = 1;
    step();
    n_total++;
    if (out_valid !== 1'b0) begin
      $display("FAIL flush_discard: got v=%b need 0", out_valid);
    end else n_pass++;
    flush = 0;
    step();
    flush = 1; in_valid = 0;
    step();
    n_total++;
    if (out_valid !== 1'b0) begin
      $display("FAIL flush_clear: got v=%b need 0", out_valid);
    end else n_pass++;
    drain();
  endtask

`ifdef ALU_OPND_LITPFX_EN
  task automatic test_prefix();
    idle_inputs();
    in_valid = 1; prefix = 1; imm = 8'h12;
    step();
    n_total++;
    if (out_valid !== 1'b0) begin
      $display("FAIL pfx_no_out: got v=%b need 0", out_valid);
    end else n_pass++;
    prefix = 0; select_imm = 1; imm = 8'h34;
    step();
    n_total++;
    if (out_valid !== 1'b1 || b !== 16'h1234) begin
      $display("FAIL pfx_one: got v=%b b=%h need 1 1234", out_valid, b);
    end else n_pass++;
    prefix = 1; select_imm = 0; imm = 8'h12;
    step();
    imm = 8'h34;
    step();
    prefix = 0; select_imm = 1; imm = 8'h56;
    step();
    n_total++;
    if (out_valid !== 1'b1 || b !== 16'h3456) begin
      $display("FAIL pfx_two: got v=%b b=%h need 1 3456", out_valid, b);
    end else n_pass++;
    prefix = 1; select_imm = 0; imm = 8'h12;
    step();
    in_valid = 0; prefix = 0; flush = 1;
    step();
    flush = 0; in_valid = 1; select_imm = 1; imm = 8'h34;
    step();
    n_total++;
    if (b !== 16'h0034) begin
      $display("FAIL pfx_flush: got b=%h need 0034", b);
    end else n_pass++;
    prefix = 1; select_imm = 0; imm = 8'h12;
    step();
    in_valid = 0; prefix = 0; rst = 1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
    n_total++;
    if (out_valid !== 1'b0) begin
      $display("FAIL pfx_rst_out: got v=%b need 0", out_valid);
    end else n_pass++;
    in_valid = 1; select_imm = 1; imm = 8'h34;
    step();
    n_total++;
    if (b !== 16'h0034) begin
      $display("FAIL pfx_rst: got b=%h need 0034", b);
    end else n_pass++;
    drain();
  endtask
`else
  task automatic test_prefix();
    idle_inputs();
    in_valid = 1; prefix = 1; select_imm = 1; imm = 8'hFF;
    step();
    n_total++;
    if (out_valid !== 1'b1 || b !== 16'hFFFF) begin
      $display("FAIL pfx_ignored: got v=%b b=%h need 1 FFFF", out_valid, b);
    end else n_pass++;
    drain();
  endtask
`endif

  task automatic test_random();
    int errs = 0;
    idle_inputs();
    for (int i = 0; i < 400; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      b_op       = 2'($urandom_range(0, 3));
      swap       = 1'($urandom_range(0, 1));
      select_imm = 1'($urandom_range(0, 1));
      prefix     = ($urandom_range(0, 3) == 0);
      flush      = ($urandom_range(0, 15) == 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      t   = 16'($urandom);
      pc  = 16'($urandom);
      n   = 16'($urandom);
      r   = 16'($urandom);
      mem = 16'($urandom);
      imm = 8'($urandom);
      #1;
      n_total++;
      if (in_ready !== (!m_valid || out_ready)) begin
        if (errs < 10)
          $display("FAIL rand_ready[%0d]: got %b need %b",
                   i, in_ready, !m_valid || out_ready);
        errs++;
      end else n_pass++;
      step();
      n_total++;
      if (out_valid !== m_valid ||
          (m_valid && (a !== m_a || b !== m_b))) begin
        if (errs < 10)
          $display("FAIL rand_out[%0d]: got v=%b a=%h b=%h need v=%b a=%h b=%h",
                   i, out_valid, a, b, m_valid, m_a, m_b);
        errs++;
      end else n_pass++;
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_basic_ops();
    test_stall();
    test_flush();
    test_prefix();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
